dpwm_core: RTL and testbench



---
 rtl/dpwm_pkg.sv | 13 +
 rtl/dpwm_counter.sv | 35 +++
 rtl/dpwm_core.sv | 62 ++++++
 tb/tb_dpwm_core.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dpwm_pkg.sv
// Shared constants and the window-decode helper for the DPWM core.
package dpwm_pkg;

  localparam int unsigned DPWM_PERIOD   = 20;
  localparam int unsigned DPWM_DUTY     = 10;
  localparam int unsigned DPWM_DEADTIME = 2;

  function automatic logic in_window(input int unsigned value, input int unsigned lo,
                                     input int unsigned hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/dpwm_counter.sv
// Modulo-Period free-running counter. It is cleared synchronously while disabled.
module dpwm_counter #(
  parameter int unsigned Period = 20,
  parameter int unsigned CntW   = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  output logic [CntW-1:0] cnt_o,
  output logic [CntW-1:0] cnt_next_o
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(Period - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/dpwm_core.sv
// Complementary PWM generator with dead time. c1 and c2 come straight from flops that
// are decoded from the next count, so the outputs track the current count with no lag.
module dpwm_core
  import dpwm_pkg::*;
#(
  parameter int unsigned PERIOD   = DPWM_PERIOD,
  parameter int unsigned DUTY     = DPWM_DUTY,
  parameter int unsigned DEADTIME = DPWM_DEADTIME
) (
  input  logic i_clk,
  input  logic reset,
  input  logic enable,
  output logic c1,
  output logic c2
);

  localparam int unsigned CNT_W = $clog2(PERIOD);

  if ((DEADTIME < 1) || (DEADTIME >= DUTY) || (DUTY + DEADTIME >= PERIOD)) begin : g_bad_params
    $fatal(1, "dpwm_core: illegal PERIOD/DUTY/DEADTIME combination");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             c1_d, c1_q;
  logic             c2_d, c2_q;

  dpwm_counter #(
    .Period(PERIOD),
    .CntW  (CNT_W)
  ) u_counter (
    .clk_i     (i_clk),
    .rst_ni    (reset),
    .en_i      (enable),
    .cnt_o     (cnt),
    .cnt_next_o(cnt_next)
  );

  // Dead time sits at the start of each window, so the windows can never overlap.
  always_comb begin
    c1_d = 1'b0;
    c2_d = 1'b0;
    if (enable) begin
      c1_d = in_window(32'(cnt_next), DEADTIME, DUTY - 1);
      c2_d = in_window(32'(cnt_next), DUTY + DEADTIME, PERIOD - 1);
    end
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      c1_q <= 1'b0;
      c2_q <= 1'b0;
    end else begin
      c1_q <= c1_d;
      c2_q <= c2_d;
    end
  end

  assign c1 = c1_q;
  assign c2 = c2_q;

endmodule

// File: tb/tb_dpwm_core.sv
// Directed bench for dpwm_core: default 20/10/2 instance plus a 10/4/1 instance.
module tb_dpwm_core;

  logic i_clk;
  logic reset;
  logic enable;
  logic c1, c2;
  logic s_c1, s_c2;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt = 0;
  int s_cnt = 0;

  dpwm_core dut (
    .i_clk (i_clk),
    .reset (reset),
    .enable(enable),
    .c1    (c1),
    .c2    (c2)
  );

  dpwm_core #(
    .PERIOD  (10),
    .DUTY    (4),
    .DEADTIME(1)
  ) dut_small (
    .i_clk (i_clk),
    .reset (reset),
    .enable(enable),
    .c1    (s_c1),
    .c2    (s_c2)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  always @(negedge i_clk) begin
    assert (!(c1 && c2)) else $error("c1 and c2 overlap");
    assert (!(s_c1 && s_c2)) else $error("s_c1 and s_c2 overlap");
  end

  // Advance one edge, then update the reference counts from what the edge saw.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (!reset || !enable) begin
      m_cnt = 0;
      s_cnt = 0;
    end else begin
      m_cnt = (m_cnt == 19) ? 0 : m_cnt + 1;
      s_cnt = (s_cnt == 9) ? 0 : s_cnt + 1;
    end
  endtask

  task automatic check_release();
    tick();
    n_cmp++;
    if (c1 !== 1'b0 || dut.cnt !== 5'd1) begin
      n_bad++;
      $display("FAIL release_edge1: c1=%b cnt=%0d, required c1=0 cnt=1", c1, dut.cnt);
    end
    tick();
    n_cmp++;
    if (c1 !== 1'b1 || dut.cnt !== 5'd2) begin
      n_bad++;
      $display("FAIL release_edge2: c1=%b cnt=%0d, required c1=1 cnt=2", c1, dut.cnt);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (c1 !== 1'b0 || c2 !== 1'b0 || dut.cnt !== 5'd0) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: c1=%b c2=%b cnt=%0d, required 0 0 0", i, c1, c2,
                 dut.cnt);
      end
    end
    reset = 1'b1;
    check_release();
  endtask

  task automatic test_run();
    logic exp1, exp2, sexp1, sexp2;
    logic prev1, sprev1;
    int   last = 0, slast = 0, hi1 = 0, hi2 = 0, shi1 = 0, shi2 = 0;
    bit   seen = 0, sseen = 0;
    prev1  = c1;
    sprev1 = s_c1;
    for (int i = 0; i < 250; i++) begin
      tick();
      exp1  = (m_cnt >= 2) && (m_cnt <= 9);
      exp2  = (m_cnt >= 12) && (m_cnt <= 19);
      sexp1 = (s_cnt >= 1) && (s_cnt <= 3);
      sexp2 = (s_cnt >= 5) && (s_cnt <= 9);
      n_cmp++;
      if (c1 !== exp1 || c2 !== exp2) begin
        n_bad++;
        $display("FAIL run_window cnt=%0d: c1=%b c2=%b, required c1=%b c2=%b", m_cnt, c1, c2,
                 exp1, exp2);
      end
      n_cmp++;
      if (s_c1 !== sexp1 || s_c2 !== sexp2) begin
        n_bad++;
        $display("FAIL small_window cnt=%0d: c1=%b c2=%b, required c1=%b c2=%b", s_cnt, s_c1,
                 s_c2, sexp1, sexp2);
      end
      n_cmp++;
      if ((c1 && c2) !== 1'b0) begin
        n_bad++;
        $display("FAIL overlap at step %0d: c1&c2=%b, required 0", i, c1 && c2);
      end
      if (c1 && !prev1) begin
        if (seen) begin
          n_cmp++;
          if (i - last != 20 || hi1 != 8 || hi2 != 8) begin
            n_bad++;
            $display("FAIL period: len=%0d c1_hi=%0d c2_hi=%0d, required 20 8 8", i - last, hi1,
                     hi2);
          end
        end
        seen = 1;
        last = i;
        hi1  = 0;
        hi2  = 0;
      end
      if (s_c1 && !sprev1) begin
        if (sseen) begin
          n_cmp++;
          if (i - slast != 10 || shi1 != 3 || shi2 != 5) begin
            n_bad++;
            $display("FAIL small_period: len=%0d c1_hi=%0d c2_hi=%0d, required 10 3 5",
                     i - slast, shi1, shi2);
          end
        end
        sseen = 1;
        slast = i;
        shi1  = 0;
        shi2  = 0;
      end
      if (c1) hi1++;
      if (c2) hi2++;
      if (s_c1) shi1++;
      if (s_c2) shi2++;
      prev1  = c1;
      sprev1 = s_c1;
    end
    n_cmp++;
    if (!seen || !sseen) begin
      n_bad++;
      $display("FAIL run_rises: seen=%0b small_seen=%0b, required 1 1", seen, sseen);
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 40 && m_cnt != 5; i++) tick();
    n_cmp++;
    if (c1 !== 1'b1 || dut.cnt !== 5'd5) begin
      n_bad++;
      $display("FAIL pre_drop: c1=%b cnt=%0d, required c1=1 cnt=5", c1, dut.cnt);
    end
    enable = 1'b0;
    tick();
    n_cmp++;
    if (c1 !== 1'b0 || c2 !== 1'b0 || dut.cnt !== 5'd0) begin
      n_bad++;
      $display("FAIL enable_drop: c1=%b c2=%b cnt=%0d, required 0 0 0", c1, c2, dut.cnt);
    end
    tick();
    n_cmp++;
    if (c1 !== 1'b0 || c2 !== 1'b0 || dut.cnt !== 5'd0) begin
      n_bad++;
      $display("FAIL enable_idle: c1=%b c2=%b cnt=%0d, required 0 0 0", c1, c2, dut.cnt);
    end
    enable = 1'b1;
    check_release();
  endtask

  task automatic test_async_reset();
    time t0;
    for (int i = 0; i < 40 && m_cnt != 15; i++) tick();
    n_cmp++;
    if (c2 !== 1'b1 || c1 !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_reset: c1=%b c2=%b, required c1=0 c2=1", c1, c2);
    end
    #2;
    t0    = $time;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (c2 !== 1'b0 || c1 !== 1'b0 || dut.cnt !== 5'd0) begin
      n_bad++;
      $display("FAIL async_reset: c1=%b c2=%b cnt=%0d, required 0 0 0", c1, c2, dut.cnt);
    end
    n_cmp++;
    if (i_clk !== 1'b1 || $time - t0 != 1) begin
      n_bad++;
      $display("FAIL async_no_edge: clk=%b dt=%0t, required clk=1 dt=1", i_clk, $time - t0);
    end
    tick();
    tick();
    n_cmp++;
    if (c1 !== 1'b0 || c2 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_held: c1=%b c2=%b, required 0 0", c1, c2);
    end
    reset = 1'b1;
    check_release();
  endtask

  initial begin
    test_reset();
    test_run();
    test_enable_drop();
    test_async_reset();
    test_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
